// File: rtl/vcfg_cluster_dispatcher.sv
// Vector-configuration dispatcher: decodes vsetvli/vsetivli/vsetvl, keeps the
// architectural vl/vtype, splits vl element-interleaved over the clusters,
// broadcasts the new configuration to every cluster and then returns vl.
// vtype bit layout on all vtype ports: {vill, vma, vta, vsew[2:0], vlmul[2:0]}.
module vcfg_cluster_dispatcher #(
   parameter int unsigned NrClusters = 4,
   parameter int unsigned VLEN       = 1024,
   parameter int unsigned ELEN       = 64,
   parameter int unsigned XLEN       = 64,
   parameter int unsigned VlWidth    = $clog2(NrClusters*VLEN)+1,
   parameter int unsigned ClVlWidth  = $clog2(VLEN)+1
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            req_valid_i,
   output logic                            req_ready_o,
   input  logic [31:0]                     insn_i,
   input  logic [XLEN-1:0]                 rs1_i,
   input  logic [XLEN-1:0]                 rs2_i,
   output logic                            resp_valid_o,
   input  logic                            resp_ready_i,
   output logic [XLEN-1:0]                 resp_vl_o,
   output logic [VlWidth-1:0]              vl_o,
   output logic [8:0]                      vtype_o,
   output logic [NrClusters-1:0]           cl_valid_o,
   input  logic [NrClusters-1:0]           cl_ready_i,
   output logic [NrClusters*ClVlWidth-1:0] cl_vl_o,
   output logic [8:0]                      cl_vtype_o
);

   localparam logic [2:0]         MaxSew    = 3'($clog2(ELEN/8));
   localparam int unsigned        ClShift   = $clog2(NrClusters);
   localparam logic [VlWidth-1:0] VlmaxSew8 = VlWidth'(NrClusters*VLEN/8);
   localparam logic [8:0]         VtypeIll  = 9'h100;

   typedef enum logic [1:0] {IDLE, BCAST, RESP} state_e;

   state_e                  state_q, state_d;
   logic [NrClusters-1:0]   done_q, done_d;
   logic [VlWidth-1:0]      vl_q, new_vl, vlmax, vl_rem;
   logic [8:0]              vtype_q, new_vtype;
   logic                    cfg_load;

   logic                    is_cfg_op, is_vsetvli, is_vsetivli, is_vsetvl, cfg_hit;
   logic                    raw_vill, raw_vma, raw_vta, cfg_ill;
   logic [2:0]              raw_vsew, raw_vlmul;
   logic signed [4:0]       lmul_log2, sew_limit;
   logic                    unused_rs2;

   assign is_cfg_op   = (insn_i[6:0] == 7'b1010111) && (insn_i[14:12] == 3'b111);
   assign is_vsetvli  = ~insn_i[31];
   assign is_vsetivli = (insn_i[31:30] == 2'b11);
   assign is_vsetvl   = (insn_i[31:25] == 7'b1000000);
   assign cfg_hit     = is_cfg_op & (is_vsetvli | is_vsetivli | is_vsetvl);
   assign unused_rs2  = ^rs2_i[XLEN-2:8];

   // Select the raw vtype fields from the immediate or from rs2 (vsetvl).
   always_comb begin
      raw_vill  = 1'b0;
      raw_vma   = insn_i[27];
      raw_vta   = insn_i[26];
      raw_vsew  = insn_i[25:23];
      raw_vlmul = insn_i[22:20];
      if (is_vsetvl) begin
         raw_vill  = rs2_i[XLEN-1];
         raw_vma   = rs2_i[7];
         raw_vta   = rs2_i[6];
         raw_vsew  = rs2_i[5:3];
         raw_vlmul = rs2_i[2:0];
      end
   end

   // SEW must fit within ELEN*LMUL; compare in the log2 domain with signed LMUL.
   assign lmul_log2 = signed'({{2{raw_vlmul[2]}}, raw_vlmul});
   assign sew_limit = signed'({2'b00, MaxSew}) + lmul_log2;
   assign cfg_ill   = raw_vill | (raw_vsew > MaxSew) | (raw_vlmul == 3'b100) |
                      (sew_limit < signed'({2'b00, raw_vsew}));

   // VLMAX from SEW and LMUL (integer LMUL shifts left, fractional right).
   always_comb begin
      vlmax = '0;
      case (raw_vlmul)
         3'b000:  vlmax = VlmaxSew8 >> raw_vsew;
         3'b001:  vlmax = (VlmaxSew8 >> raw_vsew) << 1;
         3'b010:  vlmax = (VlmaxSew8 >> raw_vsew) << 2;
         3'b011:  vlmax = (VlmaxSew8 >> raw_vsew) << 3;
         3'b101:  vlmax = (VlmaxSew8 >> raw_vsew) >> 3;
         3'b110:  vlmax = (VlmaxSew8 >> raw_vsew) >> 2;
         3'b111:  vlmax = (VlmaxSew8 >> raw_vsew) >> 1;
         default: vlmax = '0;
      endcase
   end

   // New vl/vtype; an illegal vtype forces vill with vl=0.
   always_comb begin
      new_vl    = vl_q;
      new_vtype = {1'b0, raw_vma, raw_vta, raw_vsew, raw_vlmul};
      if (is_vsetivli) begin
         new_vl = (VlWidth'(insn_i[19:15]) < vlmax) ? VlWidth'(insn_i[19:15]) : vlmax;
      end else if (insn_i[19:15] == 5'd0) begin
         new_vl = (insn_i[11:7] == 5'd0) ? vl_q : vlmax;
      end else begin
         new_vl = (rs1_i < XLEN'(vlmax)) ? VlWidth'(rs1_i) : vlmax;
      end
      if (cfg_ill) begin
         new_vl    = '0;
         new_vtype = VtypeIll;
      end
   end

   // Control FSM: accept, broadcast until every cluster has taken it, respond.
   always_comb begin
      state_d      = state_q;
      done_d       = done_q;
      cfg_load     = 1'b0;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      cl_valid_o   = '0;
      unique case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i && cfg_hit) begin
               cfg_load = 1'b1;
               state_d  = BCAST;
            end
         end
         BCAST: begin
            cl_valid_o = ~done_q;
            done_d     = done_q | (cl_valid_o & cl_ready_i);
            if (&done_d) begin
               done_d  = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, done mask and architectural configuration registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         done_q  <= '0;
         vl_q    <= '0;
         vtype_q <= VtypeIll;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if (cfg_load) begin
            vl_q    <= new_vl;
            vtype_q <= new_vtype;
         end
      end
   end

   assign vl_rem = vl_q & VlWidth'(NrClusters-1);

   for (genvar c = 0; c < NrClusters; c++) begin : g_cl_vl
      assign cl_vl_o[c*ClVlWidth +: ClVlWidth] =
         ClVlWidth'(vl_q >> ClShift) + ClVlWidth'(VlWidth'(c) < vl_rem);
   end

   assign vl_o       = vl_q;
   assign vtype_o    = vtype_q;
   assign cl_vtype_o = vtype_q;
   assign resp_vl_o  = resp_valid_o ? XLEN'(vl_q) : '0;

endmodule

// File: tb/tb_vcfg_cluster_dispatcher.sv
// Bench for vcfg_cluster_dispatcher: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_vcfg_cluster_dispatcher;

   localparam int N    = 4;
   localparam int VLEN = 1024;
   localparam int ELEN = 64;
   localparam int XLEN = 64;
   localparam int VlW  = $clog2(N*VLEN)+1;
   localparam int ClW  = $clog2(VLEN)+1;

   localparam int PH_IDLE  = 0;
   localparam int PH_BCAST = 1;
   localparam int PH_RESP  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [31:0]       insn = '0;
   logic [XLEN-1:0]   rs1 = '0;
   logic [XLEN-1:0]   rs2 = '0;
   logic              resp_valid;
   logic              resp_ready = 1'b0;
   logic [XLEN-1:0]   resp_vl;
   logic [VlW-1:0]    vl;
   logic [8:0]        vtype;
   logic [N-1:0]      cl_valid;
   logic [N-1:0]      cl_ready = '0;
   logic [N*ClW-1:0]  cl_vl;
   logic [8:0]        cl_vtype;

   int tests = 0;
   int fails = 0;

   vcfg_cluster_dispatcher #(.NrClusters(N), .VLEN(VLEN), .ELEN(ELEN), .XLEN(XLEN)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .insn_i(insn), .rs1_i(rs1), .rs2_i(rs2), .resp_valid_o(resp_valid),
      .resp_ready_i(resp_ready), .resp_vl_o(resp_vl), .vl_o(vl), .vtype_o(vtype),
      .cl_valid_o(cl_valid), .cl_ready_i(cl_ready), .cl_vl_o(cl_vl), .cl_vtype_o(cl_vtype)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int              m_phase;
   longint unsigned m_vl, m_nvl;
   logic [8:0]      m_vtype, m_nvt;
   logic [N-1:0]    m_pending;
   int              m_cl [N];

   // Returns 1 for a configuration instruction and computes the resulting vl/vtype.
   function automatic bit model_cfg(input logic [31:0] in, input logic [63:0] a, input logic [63:0] b,
                                    input longint unsigned cur, output longint unsigned nvl,
                                    output logic [8:0] nvt);
      bit imm_form, reg_form, vl_form, bad;
      logic [7:0] f;
      int sew, num, den, code;
      longint unsigned vmax;
      nvl = cur;
      nvt = '0;
      if (in[6:0] != 7'b1010111 || in[14:12] != 3'b111) return 1'b0;
      reg_form = (in[31] == 1'b0);
      imm_form = (in[31:30] == 2'b11);
      vl_form  = (in[31:25] == 7'b1000000);
      if (!(reg_form || imm_form || vl_form)) return 1'b0;
      f    = vl_form ? b[7:0] : in[27:20];
      sew  = 8 << f[5:3];
      code = int'(f[2:0]);
      if (code < 4) begin num = 1 << code; den = 1; end
      else begin num = 1; den = 1 << (8 - code); end
      bad  = (vl_form && b[63]) || (sew > ELEN) || (code == 4) || (sew * den > ELEN * num);
      if (bad) begin
         nvl = 0;
         nvt = 9'h100;
         return 1'b1;
      end
      vmax = longint'((N * VLEN * num) / (sew * den));
      nvt  = {1'b0, f};
      if (imm_form) nvl = (longint'(in[19:15]) < vmax) ? longint'(in[19:15]) : vmax;
      else if (in[19:15] == 5'd0) nvl = (in[11:7] == 5'd0) ? cur : vmax;
      else nvl = (a < vmax) ? a : vmax;
      return 1'b1;
   endfunction

   // Deal vl elements out one by one, round-robin over the clusters.
   function automatic void model_split(input longint unsigned v);
      for (int c = 0; c < N; c++) m_cl[c] = 0;
      for (longint unsigned e = 0; e < v; e++) m_cl[int'(e % N)]++;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase   = PH_IDLE;
         m_vl      = 0;
         m_vtype   = 9'h100;
         m_pending = '0;
         model_split(0);
      end else begin
         case (m_phase)
            PH_IDLE: begin
               if (req_valid && model_cfg(insn, rs1, rs2, m_vl, m_nvl, m_nvt)) begin
                  m_vl      = m_nvl;
                  m_vtype   = m_nvt;
                  model_split(m_nvl);
                  m_pending = '1;
                  m_phase   = PH_BCAST;
               end
            end
            PH_BCAST: begin
               m_pending = m_pending & ~cl_ready;
               if (m_pending == '0) m_phase = PH_RESP;
            end
            default: if (resp_ready) m_phase = PH_IDLE;
         endcase
      end
   end

   // Per-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      logic [N*ClW-1:0] exp_cl;
      for (int c = 0; c < N; c++) exp_cl[c*ClW +: ClW] = ClW'(m_cl[c]);
      check("req_ready", {63'd0, req_ready}, {63'd0, m_phase == PH_IDLE});
      check("resp_valid", {63'd0, resp_valid}, {63'd0, m_phase == PH_RESP});
      check("cl_valid", 64'(cl_valid), (m_phase == PH_BCAST) ? 64'(m_pending) : 64'd0);
      check("vl", 64'(vl), m_vl);
      check("vtype", 64'(vtype), 64'(m_vtype));
      check("cl_vtype", 64'(cl_vtype), 64'(m_vtype));
      if (m_phase == PH_RESP) check("resp_vl", resp_vl, m_vl);
      if (m_phase == PH_BCAST) check("cl_vl", 64'(cl_vl), 64'(exp_cl));
   end

   // ---------------- stimulus ----------------
   function automatic logic [31:0] mk_vsetvli(input logic [4:0] rd, input logic [4:0] rsf, input logic [10:0] zimm);
      return {1'b0, zimm, rsf, 3'b111, rd, 7'b1010111};
   endfunction
   function automatic logic [31:0] mk_vsetivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] zimm);
      return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
   endfunction
   function automatic logic [31:0] mk_vsetvl(input logic [4:0] rd, input logic [4:0] rsf, input logic [4:0] rs2f);
      return {7'b1000000, rs2f, rsf, 3'b111, rd, 7'b1010111};
   endfunction

   // Minimum-latency transaction with every ready high; literal expectations.
   task automatic run_fast(input string name, input logic [31:0] in, input logic [63:0] a,
                           input logic [63:0] b, input logic [VlW-1:0] exp_vl,
                           input logic [8:0] exp_vt, input logic [N*ClW-1:0] exp_cl);
      cl_ready = '1; resp_ready = 1'b1;
      req_valid = 1'b1; insn = in; rs1 = a; rs2 = b;
      @(negedge clk); #1; req_valid = 1'b0;
      check({name, "_t1_cl_valid"}, 64'(cl_valid), 64'hF);
      check({name, "_t1_vl"}, 64'(vl), 64'(exp_vl));
      check({name, "_t1_vtype"}, 64'(vtype), 64'(exp_vt));
      check({name, "_t1_cl_vl"}, 64'(cl_vl), 64'(exp_cl));
      check({name, "_t1_req_ready"}, 64'(req_ready), 64'd0);
      @(negedge clk); #1;
      check({name, "_t2_resp_valid"}, 64'(resp_valid), 64'd1);
      check({name, "_t2_resp_vl"}, resp_vl, 64'(exp_vl));
      check({name, "_t2_cl_valid"}, 64'(cl_valid), 64'd0);
      @(negedge clk); #1;
      check({name, "_t3_req_ready"}, 64'(req_ready), 64'd1);
      check({name, "_t3_resp_valid"}, 64'(resp_valid), 64'd0);
   endtask

   task automatic gen_txn(output logic [31:0] in, output logic [63:0] a, output logic [63:0] b);
      int kind;
      logic [4:0] rd, rsf;
      logic [2:0] vsew, vlmul;
      logic vma, vta;
      kind  = int'($urandom_range(0, 9));
      vsew  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      vlmul = 3'($urandom_range(0, 7));
      vma   = 1'($urandom_range(0, 1));
      vta   = 1'($urandom_range(0, 1));
      rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rsf   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom_range(0, 3))
         0: a = 64'($urandom_range(0, 300));
         1: a = 64'($urandom_range(0, 5000));
         2: a = {$urandom, $urandom};
         default: a = '0;
      endcase
      b = {1'($urandom_range(0, 7) == 0), 55'd0, vma, vta, vsew, vlmul};
      case (kind)
         0, 1, 2: in = {1'b0, 3'b000, vma, vta, vsew, vlmul, rsf, 3'b111, rd, 7'b1010111};
         3, 4:    in = {2'b11, 2'b00, vma, vta, vsew, vlmul, 5'($urandom_range(0, 31)), 3'b111, rd, 7'b1010111};
         5, 6:    in = {7'b1000000, 5'($urandom_range(0, 31)), rsf, 3'b111, rd, 7'b1010111};
         7:       in = {2'b10, 5'($urandom_range(1, 31)), 5'd0, rsf, 3'b111, rd, 7'b1010111};
         8:       in = {25'($urandom), 7'b0110011};
         default: in = {1'b0, 3'b000, vma, vta, vsew, vlmul, rsf, 3'b000, rd, 7'b1010111};
      endcase
   endtask

   initial begin
      logic [31:0] t_in;
      logic [63:0] t_a, t_b;
      int cyc;

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_vtype", 64'(vtype), 64'h100);
      check("rst_vl", 64'(vl), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_cl_valid", 64'(cl_valid), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_cl_vl", 64'(cl_vl), 64'd0);
      check("rst_resp_vl", resp_vl, 64'd0);
      rst_n = 1'b1;
      @(negedge clk); #1;

      // SEW32 LMUL1, AVL 100 -> 25 per cluster
      run_fast("vsetvli_100", mk_vsetvli(5'd1, 5'd2, 11'h010), 64'd100, 64'd0,
               13'd100, 9'h010, {11'd25, 11'd25, 11'd25, 11'd25});
      // vsetivli uimm 7, SEW16 LMUL1 -> 2/2/2/1
      run_fast("vsetivli_7", mk_vsetivli(5'd1, 5'd7, 10'h008), 64'd0, 64'd0,
               13'd7, 9'h008, {11'd1, 11'd2, 11'd2, 11'd2});
      // Upper AVL bit set, SEW8 LMUL8 -> VLMAX 4096
      run_fast("vsetvli_big", mk_vsetvli(5'd1, 5'd5, 11'h003), 64'h1_0000_0003, 64'd0,
               13'd4096, 9'h003, {11'd1024, 11'd1024, 11'd1024, 11'd1024});
      // SEW64 LMUL1/8 is illegal
      run_fast("vsetvli_ill", mk_vsetvli(5'd1, 5'd2, 11'h01D), 64'd50, 64'd0,
               13'd0, 9'h100, 44'd0);

      // vsetvl SEW32 LMUL2, AVL 300 -> 256; cluster 2 and the core stall
      cl_ready = 4'b1011; resp_ready = 1'b0;
      req_valid = 1'b1; insn = mk_vsetvl(5'd1, 5'd3, 5'd4); rs1 = 64'd300; rs2 = 64'h11;
      @(negedge clk); #1; req_valid = 1'b0;
      check("vsetvl_c1_cl_valid", 64'(cl_valid), 64'hF);
      check("vsetvl_vl", 64'(vl), 64'd256);
      check("vsetvl_cl_vl", 64'(cl_vl), 64'({11'd64, 11'd64, 11'd64, 11'd64}));
      repeat (3) begin
         @(negedge clk); #1;
         check("vsetvl_stall_cl_valid", 64'(cl_valid), 64'b0100);
      end
      cl_ready = 4'hF;
      repeat (3) begin
         @(negedge clk); #1;
         check("vsetvl_resp_valid", 64'(resp_valid), 64'd1);
         check("vsetvl_resp_vl", resp_vl, 64'd256);
         check("vsetvl_req_ready", 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk); #1;
      check("vsetvl_back_idle", 64'(req_ready), 64'd1);

      // Asynchronous reset in the middle of a broadcast
      cl_ready = '0;
      req_valid = 1'b1; insn = mk_vsetivli(5'd1, 5'd9, 10'h010); rs1 = '0; rs2 = '0;
      @(negedge clk); #1; req_valid = 1'b0;
      check("arst_bcast_cl_valid", 64'(cl_valid), 64'hF);
      rst_n = 1'b0;
      #1;
      check("arst_vtype", 64'(vtype), 64'h100);
      check("arst_vl", 64'(vl), 64'd0);
      check("arst_req_ready", 64'(req_ready), 64'd1);
      check("arst_cl_valid", 64'(cl_valid), 64'd0);
      check("arst_resp_valid", 64'(resp_valid), 64'd0);
      check("arst_cl_vl", 64'(cl_vl), 64'd0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;

      // Randomized traffic against the model
      for (int i = 0; i < 200; i++) begin
         gen_txn(t_in, t_a, t_b);
         req_valid  = 1'b1; insn = t_in; rs1 = t_a; rs2 = t_b;
         cl_ready   = N'($urandom);
         resp_ready = 1'($urandom_range(0, 1));
         @(negedge clk); #1;
         cyc = 0;
         while (!req_ready && cyc < 100) begin
            gen_txn(t_in, t_a, t_b);
            req_valid  = 1'($urandom_range(0, 1)); insn = t_in; rs1 = t_a; rs2 = t_b;
            cl_ready   = N'($urandom);
            resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            cyc++;
         end
         req_valid = 1'b0;
         if (cyc >= 100) begin
            check("return_to_idle", 64'(req_ready), 64'd1);
            break;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
